mem64_line_responder: RTL and testbench
=======================================

Name: mem64_line_responder

Overview:
- Memory-side responder for the 64-bit line-burst interface driven by the L1 data cache miss/writeback engine.
- Accepts line-aligned 8-beat write bursts (victim writeback) and 8-beat read bursts (line fill).
- Backing store is a synchronous 64-bit-wide BRAM array.
- Sits directly below the cache and acts as the simulation and FPGA main-memory endpoint.

Parameters:
- ADDR_BITS, 16: byte-address width. Store holds 2^(ADDR_BITS-3) 64-bit words.
- READ_LAT, 2: idle cycles between read-burst acceptance and first rvalid. Legal range 1..15.
- LINE_BEATS, 8: beats per burst. Fixed at 8 (64-byte line); other values are unsupported.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- req  in  1  burst request; initiator holds it high for the whole burst
- wr  in  1  1 = write burst, 0 = read burst; sampled when a burst is accepted
- addr  in  ADDR_BITS  byte address of line base; addr[5:0] ignored (line-aligned)
- wdata  in  64  write beat data; beat b carries bytes base+8b .. base+8b+7, little-endian
- ready  out  1  write beat accepted at this edge when req&ready
- rvalid  out  1  read beat b valid on rdata this cycle
- rdata  out  64  read beat data, same byte packing as wdata

Behaviour:
- Reset (async): state=IDLE, ready=0, rvalid=0, rdata=0, beat=0, latency counter=0. Memory contents are NOT cleared and are preserved across reset.
- States: IDLE, WR, RLAT, RD.
- Latched on acceptance: line base = {addr[ADDR_BITS-1:6], 6'b0}. Word index = base[ADDR_BITS-1:3] + beat. Beat counter is 3-bit and wraps 7->0 at burst end.
- IDLE:
  - req&wr: latch base, beat=0, ->WR; ready=1 from the next cycle.
  - req&!wr: latch base, load latency counter with READ_LAT-1, ->RLAT.
  - req=0: remain in IDLE, outputs 0.
- WR:
  - ready=1 every cycle.
  - Each edge with req=1: write wdata to word[base+beat], beat++.
  - On the edge that accepts beat 7: ->IDLE and ready=0 next cycle. Exactly 8 words written.
  - The initiator presents beat 0 data with req and advances data only on req&ready.
- RLAT: count down. At 0, ->RD and drive rvalid=1 with rdata=word[base+0] on the next cycle. First rvalid appears READ_LAT+1 cycles after the accept edge.
- RD:
  - rvalid=1 for exactly 8 consecutive cycles; rdata = word[base+beat] in cycle beat.
  - rdata and rvalid are registered; the array read is launched one cycle ahead.
  - After beat 7: ->IDLE, rvalid=0, rdata holds its last value.
- Back-to-back bursts:
  - The initiator keeps req high and flips wr 1->0 and addr in the cycle after the last write beat. IDLE sees req&!wr in that cycle and starts the read with no extra dead cycle.
  - After the last read beat the initiator drops req. A req still high in the IDLE cycle after RD starts a new burst (the initiator is required not to do this).
- Abort: req=0 in WR, RLAT or RD -> IDLE next edge with ready=0 and rvalid=0. Beats already written stay written.
- Read-after-write to the same line returns the new data, because the write completes before the read is accepted.
- Reset mid-burst: burst discarded immediately. Partial writes remain in the array.
- addr and wr changes during a burst are ignored.

Test Plan:
- Write then read line 0x0140: write burst with wdata beat b = 0x1111_0000_0000_0000+b, then read 0x0140. Required: ready high exactly 8 cycles; first rvalid 3 cycles after read accept (READ_LAT=2); rvalid 8 cycles with rdata = 0x1111_0000_0000_0000 .. +7 in order.
- Back-to-back writeback+fill: write line 0x0400 (data 0xA5A5..A5A0+b), then keep req high with wr=0, addr=0x0400 in the very next cycle. Required: read accepted that cycle, first rvalid 3 cycles later, beats 0xA5A5..A5A0..+7.
- Unaligned address: read with addr=0x017F after a write to 0x0140. Required: data identical to a read of 0x0140.
- Abort: drop req after 3 write beats to 0x0800 with wdata=0xDEAD_0000_0000_000b, then read 0x0800. Required: beats 0..2 new, beats 3..7 old contents; ready=0 one edge after the drop.
- Reset mid-read: assert rst during RD beat 4. Required: rvalid=0 and ready=0 immediately. A following read of the same line returns all 8 beats correctly.
- Edge addresses: write/read line 0xFFC0. Required: words 0x1FF8..0x1FFF correct, no wrap into line 0.

Source files
------------

// File: rtl/mem64_line_if.sv
// Line-burst bus between the cache miss/writeback engine (master) and the
// main-memory responder (slave). One 64-bit beat per cycle, 8 beats per line.
interface mem64_line_if #(
    parameter int ADDR_BITS = 16
) ();
    logic                 req;
    logic                 wr;
    logic [ADDR_BITS-1:0] addr;
    logic [63:0]          wdata;
    logic                 ready;
    logic                 rvalid;
    logic [63:0]          rdata;

    modport master (
        output req, wr, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, wr, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/mem64_line_responder.sv
// Memory-side responder for 64-byte line bursts. Write bursts store eight
// 64-bit beats into a synchronous BRAM array; read bursts return eight beats
// after a programmable latency. Memory contents survive reset.
module mem64_line_responder #(
    parameter int ADDR_BITS  = 16,
    parameter int READ_LAT   = 2,
    parameter int LINE_BEATS = 8
) (
    input logic         clk,
    input logic         rst,
    mem64_line_if.slave bus
);
    localparam int BEAT_W = $clog2(LINE_BEATS);
    localparam int WORD_W = ADDR_BITS - 3;
    localparam int LINE_W = WORD_W - BEAT_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
    localparam logic [3:0]        LAT_INIT  = 4'(READ_LAT - 1);

    typedef enum logic [1:0] {IDLE, WR, RLAT, RD} state_t;

    state_t              state_q, state_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [3:0]          lat_q, lat_d;
    logic                rvalid_q;
    logic [63:0]         rdata_q;
    logic                mem_we;
    logic                mem_re;
    logic [WORD_W-1:0]   word_idx;
    logic [63:0]         mem [2**WORD_W];
    logic                unused_addr_bits;

    // The line base has its low bits forced to zero, so the word index is
    // simply the latched line number concatenated with the beat counter.
    assign word_idx         = {line_q, beat_q};
    assign unused_addr_bits = &{1'b0, bus.addr[ADDR_BITS-LINE_W-1:0]};

    assign bus.ready  = (state_q == WR);
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;

    // Next-state and array-strobe decode for the burst sequencer.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    line_d  = bus.addr[ADDR_BITS-1 -: LINE_W];
                    beat_d  = '0;
                    lat_d   = LAT_INIT;
                    state_d = bus.wr ? WR : RLAT;
                end
            end
            WR: begin
                if (!bus.req) begin
                    state_d = IDLE;
                end else begin
                    mem_we = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            RLAT: begin
                if (!bus.req) begin
                    state_d = IDLE;
                end else if (lat_q != 4'd0) begin
                    lat_d = lat_q - 4'd1;
                end else begin
                    // Beat 0 is read on the same edge rvalid rises.
                    mem_re  = 1'b1;
                    beat_d  = beat_q + 1'b1;
                    state_d = RD;
                end
            end
            RD: begin
                // beat_q wraps back to 0 once beat 7 has been read out.
                if (!bus.req || beat_q == '0) begin
                    state_d = IDLE;
                end else begin
                    mem_re = 1'b1;
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and registered rvalid, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            line_q   <= '0;
            beat_q   <= '0;
            lat_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            beat_q   <= beat_d;
            lat_q    <= lat_d;
            rvalid_q <= mem_re;
        end
    end

    // BRAM write port; no reset so contents persist across rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= bus.wdata;
        end
    end

    // BRAM registered read port; holds the last beat when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (mem_re) begin
            rdata_q <= mem[word_idx];
        end
    end
endmodule

// File: tb/tb_mem64_line_responder.sv
// Bench for mem64_line_responder: directed line scenarios plus randomized
// bursts, checked every cycle against a per-cycle expectation schedule built
// from a word-array model of memory.
module tb_mem64_line_responder;
    localparam int AB   = 16;
    localparam int RL   = 2;
    localparam int NCYC = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem64_line_if #(.ADDR_BITS(AB)) bus ();

    mem64_line_responder #(.ADDR_BITS(AB), .READ_LAT(RL), .LINE_BEATS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          exp_rdy [NCYC];
    bit          exp_rv  [NCYC];
    bit          exp_kn  [NCYC];
    logic [63:0] exp_rd  [NCYC];
    logic [63:0] mdl [8192];
    bit          mkn [8192];
    logic [63:0] wbuf [8];
    logic [63:0] ebuf [8];
    logic [63:0] cap [$];
    int          rdy_cnt = 0;
    int          first_rv = -1;
    int          na;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp);
    endtask

    // Per-cycle comparison against the expectation schedule.
    always @(negedge clk) begin
        if (cyc < NCYC) begin
            chk("ready", 64'(bus.ready), 64'(exp_rdy[cyc]));
            chk("rvalid", 64'(bus.rvalid), 64'(exp_rv[cyc]));
            if (exp_rv[cyc] && exp_kn[cyc]) chk("rdata", bus.rdata, exp_rd[cyc]);
        end
        if (bus.ready) rdy_cnt++;
        if (bus.rvalid) begin
            cap.push_back(bus.rdata);
            if (first_rv < 0) first_rv = cyc;
        end
    end

    initial begin
        #(NCYC * 10);
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write burst presenting k beats (8 = full line). Called in cycle n.
    task automatic wr_burst(input logic [15:0] a, input int k, input bit keep);
        int n;
        int last;
        int w0;
        n    = cyc;
        w0   = int'({a[15:6], 3'b000});
        last = (k < 8) ? n + 1 + k : n + 8;
        for (int c = n + 1; c <= last; c++) if (c < NCYC) exp_rdy[c] = 1'b1;
        for (int b = 0; b < k; b++) begin
            mdl[w0 + b] = wbuf[b];
            mkn[w0 + b] = 1'b1;
        end
        bus.req   = 1'b1;
        bus.wr    = 1'b1;
        bus.addr  = a;
        bus.wdata = wbuf[0];
        step();
        for (int b = 0; b < k; b++) begin
            bus.wdata = wbuf[b];
            bus.addr  = 16'($urandom);
            bus.wr    = 1'($urandom);
            step();
        end
        if (!keep) bus.req = 1'b0;
    endtask

    // Read burst holding req for j cycles after the request cycle (j >= RL+8 = full).
    task automatic rd_burst(input logic [15:0] a, input int j);
        int n;
        int d;
        int last;
        int w0;
        n    = cyc;
        w0   = int'({a[15:6], 3'b000});
        d    = (j >= RL + 8) ? n + RL + 9 : n + 1 + j;
        last = (n + RL + 8 < d) ? n + RL + 8 : d;
        for (int b = 0; b < 8; b++) begin
            int c;
            c = n + RL + 1 + b;
            if (c <= last && c < NCYC) begin
                exp_rv[c] = 1'b1;
                exp_kn[c] = mkn[w0 + b];
                exp_rd[c] = mdl[w0 + b];
            end
        end
        bus.req  = 1'b1;
        bus.wr   = 1'b0;
        bus.addr = a;
        while (cyc < d) begin
            step();
            bus.addr = 16'($urandom);
            bus.wr   = 1'($urandom);
        end
        bus.req = 1'b0;
    endtask

    // Read whose burst is cut by rst while beat 4 is on the bus.
    task automatic rst_read(input logic [15:0] a);
        int n;
        int w0;
        n  = cyc;
        w0 = int'({a[15:6], 3'b000});
        for (int b = 0; b < 4; b++) begin
            exp_rv[n + RL + 1 + b] = 1'b1;
            exp_kn[n + RL + 1 + b] = mkn[w0 + b];
            exp_rd[n + RL + 1 + b] = mdl[w0 + b];
        end
        bus.req  = 1'b1;
        bus.wr   = 1'b0;
        bus.addr = a;
        while (cyc < n + RL + 5) step();
        rst     = 1'b1;
        bus.req = 1'b0;
        #1;
        chk("rst_mid_rvalid", 64'(bus.rvalid), 64'd0);
        chk("rst_mid_ready", 64'(bus.ready), 64'd0);
        chk("rst_mid_rdata", bus.rdata, 64'd0);
        step();
        rst = 1'b0;
    endtask

    task automatic chk_cap(input string nm);
        chk({nm, "_count"}, 64'(cap.size()), 64'd8);
        for (int b = 0; b < 8; b++) begin
            logic [63:0] g;
            g = (b < cap.size()) ? cap[b] : 64'hx;
            chk(nm, g, ebuf[b]);
        end
    endtask

    initial begin
        logic [15:0] pool [4];
        logic [15:0] a;
        int          k;
        bit          keep;
        pool[0] = 16'h0140; pool[1] = 16'h0400; pool[2] = 16'h0800; pool[3] = 16'hFFC0;

        bus.req = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
        step(); step();
        rst = 1'b0;
        step();
        chk("reset_ready", 64'(bus.ready), 64'd0);
        chk("reset_rvalid", 64'(bus.rvalid), 64'd0);
        chk("reset_rdata", bus.rdata, 64'd0);

        // Write then read line 0x0140.
        for (int b = 0; b < 8; b++) wbuf[b] = 64'h1111_0000_0000_0000 + 64'(b);
        rdy_cnt = 0;
        wr_burst(16'h0140, 8, 1'b0);
        step();
        chk("t1_ready_cycles", 64'(rdy_cnt), 64'd8);
        cap.delete(); first_rv = -1; na = cyc;
        rd_burst(16'h0140, RL + 8);
        step();
        chk("t1_first_rvalid", 64'(first_rv - na), 64'd3);
        for (int b = 0; b < 8; b++) ebuf[b] = 64'h1111_0000_0000_0000 + 64'(b);
        chk_cap("t1_beat");

        // Back-to-back writeback then fill of 0x0400.
        for (int b = 0; b < 8; b++) wbuf[b] = 64'hA5A5_A5A5_A5A5_A5A0 + 64'(b);
        wr_burst(16'h0400, 8, 1'b1);
        cap.delete(); first_rv = -1; na = cyc;
        rd_burst(16'h0400, RL + 8);
        step();
        chk("t2_first_rvalid", 64'(first_rv - na), 64'd3);
        for (int b = 0; b < 8; b++) ebuf[b] = 64'hA5A5_A5A5_A5A5_A5A0 + 64'(b);
        chk_cap("t2_beat");

        // Unaligned read address.
        cap.delete();
        rd_burst(16'h017F, RL + 8);
        step();
        for (int b = 0; b < 8; b++) ebuf[b] = 64'h1111_0000_0000_0000 + 64'(b);
        chk_cap("t3_beat");

        // Aborted write after 3 beats.
        for (int b = 0; b < 8; b++) wbuf[b] = 64'h0BAD_0000_0000_0000 + 64'(b);
        wr_burst(16'h0800, 8, 1'b0);
        step();
        for (int b = 0; b < 8; b++) wbuf[b] = 64'hDEAD_0000_0000_0000 + 64'(b);
        rdy_cnt = 0;
        wr_burst(16'h0800, 3, 1'b0);
        step(); step();
        chk("t4_ready_cycles", 64'(rdy_cnt), 64'd4);
        cap.delete();
        rd_burst(16'h0800, RL + 8);
        step();
        for (int b = 0; b < 8; b++)
            ebuf[b] = (b < 3) ? 64'hDEAD_0000_0000_0000 + 64'(b) : 64'h0BAD_0000_0000_0000 + 64'(b);
        chk_cap("t4_beat");

        // Reset during read beat 4, then a clean re-read.
        rst_read(16'h0800);
        step();
        cap.delete();
        rd_burst(16'h0800, RL + 8);
        step();
        chk_cap("t5_beat");

        // Top line must not wrap into line 0.
        for (int b = 0; b < 8; b++) wbuf[b] = 64'h0000_0000_C0DE_0000 + 64'(b);
        wr_burst(16'h0000, 8, 1'b0);
        step();
        for (int b = 0; b < 8; b++) wbuf[b] = 64'hE0E0_0000_0000_0000 + 64'(b);
        wr_burst(16'hFFC0, 8, 1'b0);
        step();
        chk("t6_model_top", mdl[8191], 64'hE0E0_0000_0000_0007);
        cap.delete();
        rd_burst(16'hFFC0, RL + 8);
        step();
        for (int b = 0; b < 8; b++) ebuf[b] = 64'hE0E0_0000_0000_0000 + 64'(b);
        chk_cap("t6_top_beat");
        cap.delete();
        rd_burst(16'h0000, RL + 8);
        step();
        for (int b = 0; b < 8; b++) ebuf[b] = 64'h0000_0000_C0DE_0000 + 64'(b);
        chk_cap("t6_line0_beat");

        // Randomized bursts with aborts, back-to-back and unaligned addresses.
        repeat (60) begin
            a = ($urandom_range(0, 4) == 4) ? 16'($urandom) : pool[$urandom_range(0, 3)];
            a = {a[15:6], 6'($urandom)};
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < 8; b++) wbuf[b] = {$urandom, $urandom};
                k    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
                keep = (k == 8) && ($urandom_range(0, 1) == 1);
                wr_burst(a, k, keep);
                if (!keep) step();
            end
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, RL + 7) : RL + 8;
            rd_burst(a, k);
            repeat ($urandom_range(1, 3)) step();
        end

        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
